// File: rtl/acc_pkg.sv
// Shared widths, limits and FSM state type for the accumulator put sequencer.
package acc_pkg;

  localparam int unsigned DATA_W        = 8;
  localparam int unsigned CTR_W_DEFAULT = 12;
  localparam int unsigned MAX_OPERANDS  = 3;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

endpackage

// File: rtl/ack_timer.sv
// Wait timer for the echo handshake: flags the last cycle of a TIMEOUT-cycle wait window.
module ack_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LastCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed wait cycles, so this is the TIMEOUT-th one.
  assign expired_o = en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/acc_put_sequencer.sv
// Issues put/op commands to an accumulator, tags each with control_ctr and waits for the echo.
module acc_put_sequencer
  import acc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CTR_W   = CTR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_is_op,
  input  logic [DATA_W-1:0] cmd_value,
  output logic              putEn,
  output logic              opEn,
  output logic [DATA_W-1:0] value,
  output logic [CTR_W-1:0]  control_ctr,
  input  logic [CTR_W-1:0]  accumulator_ctr,
  output logic [1:0]        operand_count,
  output logic              done,
  output logic              overflow_err,
  output logic              timeout_err
);

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              put_en_q, put_en_d;
  logic              op_en_q, op_en_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic [CTR_W-1:0]  ctr_q, ctr_d;
  logic [1:0]        count_q, count_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              to_q, to_d;

  logic timer_clear;
  logic timer_en;
  logic expired;
  logic ack;

  assign timer_en = (state_q == WAIT_ACK);
  assign ack      = (accumulator_ctr == ctr_q);

  ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_ack_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (timer_clear),
    .en_i      (timer_en),
    .expired_o (expired)
  );

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    put_en_d    = put_en_q;
    op_en_d     = op_en_q;
    value_d     = value_q;
    ctr_d       = ctr_q;
    count_d     = count_q;
    done_d      = 1'b0;
    ovf_d       = 1'b0;
    to_d        = 1'b0;
    timer_clear = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (!cmd_is_op && (count_q == 2'(MAX_OPERANDS))) begin
            ovf_d = 1'b1;
          end else begin
            state_d     = WAIT_ACK;
            ready_d     = 1'b0;
            put_en_d    = !cmd_is_op;
            op_en_d     = cmd_is_op;
            ctr_d       = ctr_q + 1'b1;
            timer_clear = 1'b1;
            if (!cmd_is_op) begin
              value_d = cmd_value;
            end
          end
        end
      end
      WAIT_ACK: begin
        // Ack is checked first so a match in the expiring cycle still completes.
        if (ack) begin
          state_d  = IDLE;
          ready_d  = 1'b1;
          put_en_d = 1'b0;
          op_en_d  = 1'b0;
          done_d   = 1'b1;
          count_d  = op_en_q ? 2'd0 : count_q + 2'd1;
        end else if (expired) begin
          state_d  = IDLE;
          ready_d  = 1'b1;
          put_en_d = 1'b0;
          op_en_d  = 1'b0;
          to_d     = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      put_en_q <= 1'b0;
      op_en_q  <= 1'b0;
      value_q  <= '0;
      ctr_q    <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      put_en_q <= put_en_d;
      op_en_q  <= op_en_d;
      value_q  <= value_d;
      ctr_q    <= ctr_d;
      count_q  <= count_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      to_q     <= to_d;
    end
  end

  assign cmd_ready     = ready_q;
  assign putEn         = put_en_q;
  assign opEn          = op_en_q;
  assign value         = value_q;
  assign control_ctr   = ctr_q;
  assign operand_count = count_q;
  assign done          = done_q;
  assign overflow_err  = ovf_q;
  assign timeout_err   = to_q;

endmodule

// File: tb/tb_acc_put_sequencer.sv
// Bench for acc_put_sequencer: directed scenarios plus random commands against a transaction model.
module tb_acc_put_sequencer;

  localparam int unsigned TO = 16;
  localparam int unsigned CW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_is_op = 1'b0;
  logic [7:0]    cmd_value = '0;
  logic          putEn;
  logic          opEn;
  logic [7:0]    value;
  logic [CW-1:0] control_ctr;
  logic [CW-1:0] accumulator_ctr = '0;
  logic [1:0]    operand_count;
  logic          done;
  logic          overflow_err;
  logic          timeout_err;

  // Transaction-level model of the sequencer's visible state.
  logic [CW-1:0] m_ctr;
  int            m_count;
  logic [7:0]    m_value;

  int checks = 0;
  int errors = 0;

  acc_put_sequencer #(
    .TIMEOUT (TO),
    .CTR_W   (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_is_op       (cmd_is_op),
    .cmd_value       (cmd_value),
    .putEn           (putEn),
    .opEn            (opEn),
    .value           (value),
    .control_ctr     (control_ctr),
    .accumulator_ctr (accumulator_ctr),
    .operand_count   (operand_count),
    .done            (done),
    .overflow_err    (overflow_err),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    m_ctr   = '0;
    m_count = 0;
    m_value = '0;
  endtask

  // One command; echo d matches from WAIT_ACK cycle d+1 onward (d >= TO never acks in time).
  task automatic issue(input bit is_op, input logic [7:0] val, input int d);
    logic [CW-1:0] tag;
    bit            ovf;
    bit            exp_done;
    int            pulse;
    @(negedge clk);
    checks++;
    if ({cmd_ready, putEn, opEn, done, overflow_err, timeout_err} !== 6'b100000) begin
      errors++;
      $display("FAIL idle_flags: got %b want 100000",
               {cmd_ready, putEn, opEn, done, overflow_err, timeout_err});
    end
    checks++;
    if ({control_ctr, operand_count, value} !== {m_ctr, 2'(m_count), m_value}) begin
      errors++;
      $display("FAIL idle_state: got ctr=%0d cnt=%0d val=%0d want ctr=%0d cnt=%0d val=%0d",
               control_ctr, operand_count, value, m_ctr, m_count, m_value);
    end
    ovf = !is_op && (m_count == 3);
    tag = m_ctr + 1'b1;
    cmd_valid       = 1'b1;
    cmd_is_op       = is_op;
    cmd_value       = val;
    accumulator_ctr = tag + 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_value = 8'($urandom);
    if (ovf) begin
      checks++;
      if ({cmd_ready, putEn, opEn, done, overflow_err, timeout_err} !== 6'b100010) begin
        errors++;
        $display("FAIL overflow_flags: got %b want 100010",
                 {cmd_ready, putEn, opEn, done, overflow_err, timeout_err});
      end
      checks++;
      if ({control_ctr, operand_count} !== {m_ctr, 2'd3}) begin
        errors++;
        $display("FAIL overflow_state: got ctr=%0d cnt=%0d want ctr=%0d cnt=3",
                 control_ctr, operand_count, m_ctr);
      end
      return;
    end
    m_ctr = tag;
    if (!is_op) m_value = val;
    if (d + 1 <= int'(TO)) begin
      pulse    = d + 2;
      exp_done = 1'b1;
    end else begin
      pulse    = TO + 1;
      exp_done = 1'b0;
    end
    for (int k = 1; k <= pulse; k++) begin
      if (k < pulse) begin
        checks++;
        if ({cmd_ready, putEn, opEn, done, overflow_err, timeout_err} !==
            {1'b0, !is_op, is_op, 3'b000}) begin
          errors++;
          $display("FAIL wait_flags cyc%0d: got %b want %b", k,
                   {cmd_ready, putEn, opEn, done, overflow_err, timeout_err},
                   {1'b0, !is_op, is_op, 3'b000});
        end
        checks++;
        if ({control_ctr, value} !== {m_ctr, m_value}) begin
          errors++;
          $display("FAIL wait_hold cyc%0d: got ctr=%0d val=%0d want ctr=%0d val=%0d", k,
                   control_ctr, value, m_ctr, m_value);
        end
      end else begin
        if (exp_done) m_count = is_op ? 0 : m_count + 1;
        checks++;
        if ({cmd_ready, putEn, opEn, done, overflow_err, timeout_err} !==
            {3'b100, exp_done, 1'b0, !exp_done}) begin
          errors++;
          $display("FAIL end_flags: got %b want %b",
                   {cmd_ready, putEn, opEn, done, overflow_err, timeout_err},
                   {3'b100, exp_done, 1'b0, !exp_done});
        end
        checks++;
        if ({control_ctr, operand_count} !== {m_ctr, 2'(m_count)}) begin
          errors++;
          $display("FAIL end_state: got ctr=%0d cnt=%0d want ctr=%0d cnt=%0d",
                   control_ctr, operand_count, m_ctr, m_count);
        end
      end
      if (k == d + 1) accumulator_ctr = tag;
      if (k < pulse) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({cmd_ready, putEn, opEn, done, overflow_err, timeout_err, control_ctr, operand_count,
         value} !== {6'b100000, {CW{1'b0}}, 2'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_state: got ready=%b put=%b op=%b ctr=%0d cnt=%0d val=%0d",
               cmd_ready, putEn, opEn, control_ctr, operand_count, value);
    end
  endtask

  task automatic test_put_echo();
    issue(1'b0, 8'd5, 1);
  endtask

  task automatic test_overflow_then_op();
    do_reset();
    issue(1'b0, 8'd7, 0);
    issue(1'b0, 8'd9, 2);
    issue(1'b0, 8'd11, 1);
    issue(1'b0, 8'd13, 0);
    issue(1'b1, 8'd0, 1);
    issue(1'b1, 8'd0, 0);
  endtask

  task automatic test_timeout();
    issue(1'b0, 8'h3c, 100);
    issue(1'b0, 8'h44, TO - 1);
    issue(1'b1, 8'd0, TO);
    issue(1'b0, 8'h21, 3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      issue(($urandom_range(3) == 0), 8'($urandom), int'($urandom_range(TO + 3)));
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    cmd_valid       = 1'b1;
    cmd_is_op       = 1'b0;
    cmd_value       = 8'ha5;
    accumulator_ctr = m_ctr + 2'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (putEn !== 1'b1) begin
      errors++;
      $display("FAIL mid_put_strobe: got %b want 1", putEn);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, putEn, opEn, done, overflow_err, timeout_err, control_ctr, operand_count,
         value} !== {6'b100000, {CW{1'b0}}, 2'd0, 8'd0}) begin
      errors++;
      $display("FAIL mid_reset_state: got ready=%b put=%b op=%b ctr=%0d cnt=%0d val=%0d",
               cmd_ready, putEn, opEn, control_ctr, operand_count, value);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({done, overflow_err, timeout_err} !== 3'b000) begin
        errors++;
        $display("FAIL mid_reset_pulse: got %b want 000", {done, overflow_err, timeout_err});
      end
    end
    rst_n   = 1'b1;
    m_ctr   = '0;
    m_count = 0;
    m_value = '0;
    issue(1'b0, 8'd3, 1);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      issue(1'b1, 8'd0, 0);
    end
    issue(1'b0, 8'd1, 0);
    issue(1'b0, 8'd2, 1);
  endtask

  initial begin
    test_reset();
    test_put_echo();
    test_overflow_then_op();
    test_timeout();
    test_random();
    test_reset_mid_wait();
    test_wrap();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  always @(negedge clk) begin
    if (rst_n && putEn && opEn) begin
      errors++;
      $display("FAIL strobe_exclusive: got putEn=1 opEn=1 want at most one");
    end
  end

endmodule
